// File: rtl/img_pkg.sv
// Shared image geometry and type definitions for the frame BRAM arbiter.
//
// Contents:
//   IMG_W, IMG_H, PIX_COUNT : default frame geometry (130 x 130 = 16900 pixels)
//   arb_state_t             : frame phase, LOAD (pixel stream in) or PROC (read-only)
//   owner_t                 : which port drives the BRAM in the current cycle
package img_pkg;

    localparam int unsigned IMG_W     = 130;
    localparam int unsigned IMG_H     = 130;
    localparam int unsigned PIX_COUNT = IMG_W * IMG_H;

    typedef enum logic {
        LOAD = 1'b0,
        PROC = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_WR   = 2'd1,
        OWN_RD0  = 2'd2,
        OWN_RD1  = 2'd3
    } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-low reset; pointer returns to "req[1] last"
//   enable  in   arbitration enabled; when low no grant is issued and the pointer
//                is parked at "req[1] last" so req[0] wins the next tie
//   req     in   [1:0] request vector
//   gnt     out  [1:0] one-hot grant, combinational from req and the pointer
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1: req[1] was granted last (so req[0] wins a tie), 0: req[0] was granted last.
    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (!enable) begin
            last_d = 1'b1;
        end else if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bram_frame_arbiter.sv
// Owner of the single-port frame BRAM. A frame is first streamed in raster order
// (LOAD), then the BRAM becomes read-only and is shared round-robin between the
// window controller (rd0) and the host readback port (rd1) (PROC). frame_done
// returns the block to LOAD for the next frame.
//
// Ports:
//   clk, reset                 clock (rising edge) and async active-low reset
//   wr_req/wr_data/wr_gnt      pixel stream input; wr_gnt accepts a pixel this cycle
//   rd0_req/rd0_addr/rd0_gnt   window controller read request and same-cycle grant
//   rd0_valid/rd0_data         read return one cycle after rd0_gnt
//   rd1_*                      same for the readback port
//   frame_done                 one-cycle pulse ending PROC
//   done_recieving             high for the whole PROC phase
//   bram_en/we/addr/wdata      BRAM drive, combinational from the winning port
//   bram_rdata                 BRAM read data, 1-cycle synchronous latency
module bram_frame_arbiter #(
    parameter int unsigned IMG_W  = img_pkg::IMG_W,
    parameter int unsigned IMG_H  = img_pkg::IMG_H,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_gnt,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_gnt,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              frame_done,
    output logic              done_recieving,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    localparam int unsigned       PixCount = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LastPix  = ADDR_W'(PixCount - 1);

    img_pkg::arb_state_t state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic                rd0_valid_q, rd1_valid_q;
    logic                arb_en;
    logic [1:0]          rd_gnt;
    img_pkg::owner_t     owner;

    // The arbiter only runs in PROC. Holding it disabled through LOAD parks its
    // pointer at "rd1 last", so every PROC phase starts with rd0 winning a tie.
    assign arb_en = reset && (state_q == img_pkg::PROC);

    rr_arbiter2 u_rr_arbiter2 (
        .clk    (clk),
        .reset  (reset),
        .enable (arb_en),
        .req    ({rd1_req, rd0_req}),
        .gnt    (rd_gnt)
    );

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= img_pkg::LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            img_pkg::LOAD: begin
                if (wr_gnt) begin
                    if (wr_cnt_q == LastPix) begin
                        state_d  = img_pkg::PROC;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            img_pkg::PROC: begin
                if (frame_done) begin
                    state_d = img_pkg::LOAD;
                end
            end
            default: state_d = img_pkg::LOAD;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: pick the port that owns the BRAM this cycle
    // ---------------------------------------------------------------------
    always_comb begin
        owner = img_pkg::OWN_NONE;
        if (reset) begin
            unique case (state_q)
                img_pkg::LOAD: begin
                    if (wr_req) begin
                        owner = img_pkg::OWN_WR;
                    end
                end
                img_pkg::PROC: begin
                    if (rd_gnt[0]) begin
                        owner = img_pkg::OWN_RD0;
                    end else if (rd_gnt[1]) begin
                        owner = img_pkg::OWN_RD1;
                    end
                end
                default: owner = img_pkg::OWN_NONE;
            endcase
        end
    end

    assign wr_gnt         = (owner == img_pkg::OWN_WR);
    assign rd0_gnt        = (owner == img_pkg::OWN_RD0);
    assign rd1_gnt        = (owner == img_pkg::OWN_RD1);
    assign done_recieving = (state_q == img_pkg::PROC);

    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        unique case (owner)
            img_pkg::OWN_WR: begin
                bram_en    = 1'b1;
                bram_we    = 1'b1;
                bram_addr  = wr_cnt_q;
                bram_wdata = wr_data;
            end
            img_pkg::OWN_RD0: begin
                bram_en   = 1'b1;
                bram_addr = rd0_addr;
            end
            img_pkg::OWN_RD1: begin
                bram_en   = 1'b1;
                bram_addr = rd1_addr;
            end
            default: begin
                bram_en = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Write counter and read-return tags
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_q    <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd0_valid_q <= rd0_gnt;
            rd1_valid_q <= rd1_gnt;
        end
    end

    // Read data is only presented to the port whose read is returning.
    assign rd0_valid = rd0_valid_q;
    assign rd1_valid = rd1_valid_q;
    assign rd0_data  = rd0_valid_q ? bram_rdata : '0;
    assign rd1_data  = rd1_valid_q ? bram_rdata : '0;

endmodule

// File: tb/tb_bram_frame_arbiter.sv
// Self-checking bench for bram_frame_arbiter: directed steps plus randomized
// traffic, compared against a frame-level reference model and a BRAM model.
module tb_bram_frame_arbiter;

    localparam int PIX = 16900;

    logic        clk;
    logic        reset;
    logic        wr_req;
    logic [7:0]  wr_data;
    logic        wr_gnt;
    logic        rd0_req;
    logic [14:0] rd0_addr;
    logic        rd0_gnt;
    logic        rd0_valid;
    logic [7:0]  rd0_data;
    logic        rd1_req;
    logic [14:0] rd1_addr;
    logic        rd1_gnt;
    logic        rd1_valid;
    logic [7:0]  rd1_data;
    logic        frame_done;
    logic        done_recieving;
    logic        bram_en;
    logic        bram_we;
    logic [14:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic [7:0]  bram_rdata;

    bram_frame_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .wr_req         (wr_req),
        .wr_data        (wr_data),
        .wr_gnt         (wr_gnt),
        .rd0_req        (rd0_req),
        .rd0_addr       (rd0_addr),
        .rd0_gnt        (rd0_gnt),
        .rd0_valid      (rd0_valid),
        .rd0_data       (rd0_data),
        .rd1_req        (rd1_req),
        .rd1_addr       (rd1_addr),
        .rd1_gnt        (rd1_gnt),
        .rd1_valid      (rd1_valid),
        .rd1_data       (rd1_data),
        .frame_done     (frame_done),
        .done_recieving (done_recieving),
        .bram_en        (bram_en),
        .bram_we        (bram_we),
        .bram_addr      (bram_addr),
        .bram_wdata     (bram_wdata),
        .bram_rdata     (bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with one-cycle read latency.
    logic [7:0] mem [0:32767];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata <= mem[bram_addr];
        end
    end

    // Reference model: frame phase, next pixel index, who won the last read,
    // expected image contents and pending read returns.
    int         errors = 0;
    int         checks = 0;
    bit         m_proc;
    int         m_wcnt;
    bit         m_last_rd1;
    bit         m_v0, m_v1;
    bit         m_k0, m_k1;
    logic [7:0] m_d0, m_d1;
    logic [7:0] ref_img [0:32767];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check every output against the model,
    // advance the model, then move to just after the next rising edge.
    task automatic step(input logic rst_v, input logic wr, input logic [7:0] wd,
                        input logic r0, input logic [14:0] a0,
                        input logic r1, input logic [14:0] a1, input logic fd);
        logic        eg_w, eg0, eg1, was_proc;
        logic [14:0] ea;
        logic [7:0]  ewd;
        reset      = rst_v;
        wr_req     = wr;
        wr_data    = wd;
        rd0_req    = r0;
        rd0_addr   = a0;
        rd1_req    = r1;
        rd1_addr   = a1;
        frame_done = fd;
        if (!rst_v) begin
            m_proc     = 1'b0;
            m_wcnt     = 0;
            m_last_rd1 = 1'b1;
            m_v0       = 1'b0;
            m_v1       = 1'b0;
        end
        #2;
        eg_w = rst_v && !m_proc && wr;
        eg0  = 1'b0;
        eg1  = 1'b0;
        if (rst_v && m_proc) begin
            if (r0 && r1) begin
                if (m_last_rd1) eg0 = 1'b1;
                else            eg1 = 1'b1;
            end else if (r0) begin
                eg0 = 1'b1;
            end else if (r1) begin
                eg1 = 1'b1;
            end
        end
        ea  = eg_w ? 15'(m_wcnt) : eg0 ? a0 : eg1 ? a1 : 15'd0;
        ewd = eg_w ? wd : 8'd0;
        check("wr_gnt",         32'(wr_gnt),         32'(eg_w));
        check("rd0_gnt",        32'(rd0_gnt),        32'(eg0));
        check("rd1_gnt",        32'(rd1_gnt),        32'(eg1));
        check("bram_en",        32'(bram_en),        32'(eg_w | eg0 | eg1));
        check("bram_we",        32'(bram_we),        32'(eg_w));
        check("bram_addr",      32'(bram_addr),      32'(ea));
        check("bram_wdata",     32'(bram_wdata),     32'(ewd));
        check("done_recieving", 32'(done_recieving), 32'(m_proc));
        check("rd0_valid",      32'(rd0_valid),      32'(m_v0));
        check("rd1_valid",      32'(rd1_valid),      32'(m_v1));
        if (!m_v0)     check("rd0_data_idle", 32'(rd0_data), 32'd0);
        else if (m_k0) check("rd0_data",      32'(rd0_data), 32'(m_d0));
        if (!m_v1)     check("rd1_data_idle", 32'(rd1_data), 32'd0);
        else if (m_k1) check("rd1_data",      32'(rd1_data), 32'(m_d1));

        was_proc = m_proc;
        m_v0 = eg0;
        m_k0 = (int'(a0) < PIX);
        m_d0 = ref_img[a0];
        m_v1 = eg1;
        m_k1 = (int'(a1) < PIX);
        m_d1 = ref_img[a1];
        if (eg0) m_last_rd1 = 1'b0;
        if (eg1) m_last_rd1 = 1'b1;
        if (eg_w) begin
            ref_img[m_wcnt] = wd;
            if (m_wcnt == PIX - 1) begin
                m_wcnt = 0;
                m_proc = 1'b1;
            end else begin
                m_wcnt++;
            end
        end
        if (rst_v && was_proc && fd) begin
            m_proc     = 1'b0;
            m_last_rd1 = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        m_proc = 1'b0; m_wcnt = 0; m_last_rd1 = 1'b1;
        m_v0 = 1'b0; m_v1 = 1'b0; m_k0 = 1'b0; m_k1 = 1'b0;
        m_d0 = '0; m_d1 = '0;
        reset = 1'b0; wr_req = 1'b0; wr_data = '0; rd0_req = 1'b0; rd0_addr = '0;
        rd1_req = 1'b0; rd1_addr = '0; frame_done = 1'b0;
        #1;

        // Reset state, then a partial frame, then reset mid-LOAD for 3 cycles.
        repeat (2) step(1'b0, 1'b1, 8'h11, 1'b1, 15'd5, 1'b1, 15'd9, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 8'(k + 100), 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 8'hAA, 1'b1, 15'd5, 1'b1, 15'd9, 1'b0);

        // Full frame, pixel k = k mod 256, writes restart at address 0.
        for (int k = 0; k < PIX; k++) begin
            step(1'b1, 1'b1, 8'(k % 256), 1'b0, '0, 1'b0, '0, 1'b0);
        end
        check("done_after_last_write", 32'(done_recieving), 32'd1);
        step(1'b1, 1'b1, 8'h55, 1'b0, '0, 1'b0, '0, 1'b0);

        // Both readers held high: strict alternation starting with rd0.
        repeat (6) step(1'b1, 1'b0, '0, 1'b1, 15'd5, 1'b1, 15'd9, 1'b0);
        // Only rd1 for 4 cycles, then both: rd0 wins first.
        repeat (4) step(1'b1, 1'b0, '0, 1'b0, 15'd5, 1'b1, 15'd9, 1'b0);
        repeat (3) step(1'b1, 1'b0, '0, 1'b1, 15'd5, 1'b1, 15'd9, 1'b0);

        // Random read traffic, some addresses past the image.
        repeat (300) begin
            step(1'b1, 1'(($urandom_range(0, 1))), 8'($urandom),
                 1'($urandom_range(0, 1)), 15'($urandom_range(0, PIX + 200)),
                 1'($urandom_range(0, 1)), 15'($urandom_range(0, PIX + 200)), 1'b0);
        end

        // rd0 granted together with frame_done; next cycle LOAD writes address 0.
        step(1'b1, 1'b0, '0, 1'b1, 15'd5, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 8'h77, 1'b0, '0, 1'b0, '0, 1'b0);
        // frame_done in LOAD is ignored.
        step(1'b1, 1'b1, 8'h78, 1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, 15'd3, 1'b1, 15'd4, 1'b1);

        // Second frame with random gaps, random data and stray frame_done pulses.
        budget = 0;
        while (!m_proc && budget < 60000) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, '0, 1'b0, '0,
                 1'($urandom_range(0, 99) == 0));
            budget++;
        end
        check("frame2_reached_proc", 32'(done_recieving), 32'd1);

        repeat (400) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 15'($urandom_range(0, PIX - 1)),
                 1'($urandom_range(0, 1)), 15'($urandom_range(0, PIX - 1)), 1'b0);
        end

        // Reset with a read in flight: valid is dropped, everything returns to LOAD.
        step(1'b1, 1'b0, '0, 1'b1, 15'd7, 1'b1, 15'd8, 1'b0);
        repeat (2) step(1'b0, 1'b1, 8'h33, 1'b1, 15'd7, 1'b1, 15'd8, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b1, 15'd7, 1'b1, 15'd8, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
